// File: rtl/id_operand_stage_pkg.sv
// Shared pipeline definitions for the decode/operand stage and its neighbours.
package id_operand_stage_pkg;

   // Instruction field positions of the source register specifiers.
   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   // Instruction word that stands for "no operation" in the pipeline.
   localparam logic [31:0] PKG_NOP_IR = 32'h0000_0000;

   // Legacy condition codes, kept so the adapter to older stages can still
   // translate valid/ready/flush into FLOW/STALL/ZERO.
   typedef enum logic [1:0] {
      COND_FLOW  = 2'd0,
      COND_STALL = 2'd1,
      COND_ZERO  = 2'd2
   } cond_e;

endpackage

// File: rtl/id_operand_stage_fwd_select.sv
// Resolves one source operand: picks the youngest matching forwarding source,
// falls back to the register-file value, and reports whether the chosen
// source is still waiting on a load.
module id_operand_stage_fwd_select #(
   parameter int XLEN = 32,
   parameter int NFWD = 3,
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0]      i_addr,
   input  logic [XLEN-1:0]      i_rf,
   input  logic [NFWD-1:0]      i_fwd_valid,
   input  logic [NFWD-1:0]      i_fwd_pending,
   input  logic [NFWD*RA_W-1:0] i_fwd_addr,
   input  logic [NFWD*XLEN-1:0] i_fwd_data,
   output logic [XLEN-1:0]      o_value,
   output logic                 o_pending
);

   logic w_hit;

   // Priority scan from the youngest source; register 0 never forwards.
   always_comb begin
      o_value   = i_rf;
      o_pending = 1'b0;
      w_hit     = 1'b0;
      if (i_addr != '0) begin
         for (int k = 0; k < NFWD; k++) begin
            if (!w_hit && i_fwd_valid[k] &&
                (i_fwd_addr[k*RA_W +: RA_W] == i_addr)) begin
               w_hit     = 1'b1;
               o_value   = i_fwd_data[k*XLEN +: XLEN];
               o_pending = i_fwd_pending[k];
            end
         end
      end
   end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-to-execute operand stage: one-entry valid/ready register holding
// IR, NPC and forwarded Rs/Rt, plus load-use hazard detection, branch
// compare flags, the HI/LO pair and a saturating stall counter.
module id_operand_stage
   import id_operand_stage_pkg::*;
#(
   parameter int              XLEN   = 32,
   parameter int              NFWD   = 3,
   parameter int              RA_W   = 5,
   parameter int              CNT_W  = 16,
   parameter logic [XLEN-1:0] NOP_IR = XLEN'(PKG_NOP_IR)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_ir,
   input  logic [XLEN-1:0]      in_npc,
   input  logic [XLEN-1:0]      rf_rs,
   input  logic [XLEN-1:0]      rf_rt,
   input  logic [NFWD-1:0]      fwd_valid,
   input  logic [NFWD-1:0]      fwd_pending,
   input  logic [NFWD*RA_W-1:0] fwd_addr,
   input  logic [NFWD*XLEN-1:0] fwd_data,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_ir,
   output logic [XLEN-1:0]      out_npc,
   output logic [XLEN-1:0]      out_rs,
   output logic [XLEN-1:0]      out_rt,
   output logic                 br_eq,
   output logic                 br_gez,
   output logic                 hazard,
   input  logic                 hi_we,
   input  logic                 lo_we,
   input  logic [XLEN-1:0]      hi_wdata,
   input  logic [XLEN-1:0]      lo_wdata,
   output logic [XLEN-1:0]      hi_q,
   output logic [XLEN-1:0]      lo_q,
   output logic [CNT_W-1:0]     stall_cnt
);

   logic [RA_W-1:0]  w_rs_addr;
   logic [RA_W-1:0]  w_rt_addr;
   logic [XLEN-1:0]  w_rs_val;
   logic [XLEN-1:0]  w_rt_val;
   logic             w_rs_pend;
   logic             w_rt_pend;
   logic             w_load;

   logic             r_valid;
   logic [XLEN-1:0]  r_ir;
   logic [XLEN-1:0]  r_npc;
   logic [XLEN-1:0]  r_rs;
   logic [XLEN-1:0]  r_rt;
   logic [XLEN-1:0]  r_hi;
   logic [XLEN-1:0]  r_lo;
   logic [CNT_W-1:0] r_stall_cnt;

   assign w_rs_addr = RA_W'(in_ir[RS_MSB:RS_LSB]);
   assign w_rt_addr = RA_W'(in_ir[RT_MSB:RT_LSB]);

   id_operand_stage_fwd_select #(
      .XLEN (XLEN),
      .NFWD (NFWD),
      .RA_W (RA_W)
   ) u_fwd_rs (
      .i_addr        (w_rs_addr),
      .i_rf          (rf_rs),
      .i_fwd_valid   (fwd_valid),
      .i_fwd_pending (fwd_pending),
      .i_fwd_addr    (fwd_addr),
      .i_fwd_data    (fwd_data),
      .o_value       (w_rs_val),
      .o_pending     (w_rs_pend)
   );

   id_operand_stage_fwd_select #(
      .XLEN (XLEN),
      .NFWD (NFWD),
      .RA_W (RA_W)
   ) u_fwd_rt (
      .i_addr        (w_rt_addr),
      .i_rf          (rf_rt),
      .i_fwd_valid   (fwd_valid),
      .i_fwd_pending (fwd_pending),
      .i_fwd_addr    (fwd_addr),
      .i_fwd_data    (fwd_data),
      .o_value       (w_rt_val),
      .o_pending     (w_rt_pend)
   );

   // A stall is needed only when the operand actually selected is still in flight.
   assign hazard   = in_valid && (w_rs_pend || w_rt_pend);
   assign in_ready = !hazard && !flush && (!r_valid || out_ready);
   assign w_load   = in_valid && in_ready;

   // Branch flags see the same forwarded operands that would be loaded.
   assign br_eq  = (w_rs_val == w_rt_val);
   assign br_gez = !w_rs_val[XLEN-1];

   // Pipeline entry: flush wins, then load, then bubble on stall, then drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_ir    <= NOP_IR;
         r_npc   <= '0;
         r_rs    <= '0;
         r_rt    <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_ir    <= NOP_IR;
         r_npc   <= '0;
         r_rs    <= '0;
         r_rt    <= '0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_ir    <= in_ir;
         r_npc   <= in_npc;
         r_rs    <= w_rs_val;
         r_rt    <= w_rt_val;
      end else if (hazard && out_ready) begin
         r_valid <= 1'b0;
         r_ir    <= NOP_IR;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   // HI/LO are written independently of the handshake and of flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (hi_we) r_hi <= hi_wdata;
         if (lo_we) r_lo <= lo_wdata;
      end
   end

   // Count load-use stall cycles, sticking at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (hazard && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign out_valid = r_valid;
   assign out_ir    = r_ir;
   assign out_npc   = r_npc;
   assign out_rs    = r_rs;
   assign out_rt    = r_rt;
   assign hi_q      = r_hi;
   assign lo_q      = r_lo;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios followed by random traffic,
// all compared against a behavioural model of the stage.
module tb_id_operand_stage;

   localparam int          XLEN  = 32;
   localparam int          NFWD  = 3;
   localparam int          RA_W  = 5;
   localparam int          CNT_W = 4;
   localparam logic [31:0] NOP   = 32'h0;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic                 clk;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [XLEN-1:0]      in_ir;
   logic [XLEN-1:0]      in_npc;
   logic [XLEN-1:0]      rf_rs;
   logic [XLEN-1:0]      rf_rt;
   logic [NFWD-1:0]      fwd_valid;
   logic [NFWD-1:0]      fwd_pending;
   logic [NFWD*RA_W-1:0] fwd_addr;
   logic [NFWD*XLEN-1:0] fwd_data;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_ir;
   logic [XLEN-1:0]      out_npc;
   logic [XLEN-1:0]      out_rs;
   logic [XLEN-1:0]      out_rt;
   logic                 br_eq;
   logic                 br_gez;
   logic                 hazard;
   logic                 hi_we;
   logic                 lo_we;
   logic [XLEN-1:0]      hi_wdata;
   logic [XLEN-1:0]      lo_wdata;
   logic [XLEN-1:0]      hi_q;
   logic [XLEN-1:0]      lo_q;
   logic [CNT_W-1:0]     stall_cnt;

   logic [RA_W-1:0] fa [NFWD];
   logic [XLEN-1:0] fd [NFWD];

   id_operand_stage #(
      .XLEN   (XLEN),
      .NFWD   (NFWD),
      .RA_W   (RA_W),
      .CNT_W  (CNT_W),
      .NOP_IR (NOP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ir       (in_ir),
      .in_npc      (in_npc),
      .rf_rs       (rf_rs),
      .rf_rt       (rf_rt),
      .fwd_valid   (fwd_valid),
      .fwd_pending (fwd_pending),
      .fwd_addr    (fwd_addr),
      .fwd_data    (fwd_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ir      (out_ir),
      .out_npc     (out_npc),
      .out_rs      (out_rs),
      .out_rt      (out_rt),
      .br_eq       (br_eq),
      .br_gez      (br_gez),
      .hazard      (hazard),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .hi_wdata    (hi_wdata),
      .lo_wdata    (lo_wdata),
      .hi_q        (hi_q),
      .lo_q        (lo_q),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack the per-source arrays onto the flat buses.
   always_comb begin
      fwd_addr = '0;
      fwd_data = '0;
      for (int k = 0; k < NFWD; k++) begin
         fwd_addr[k*RA_W +: RA_W] = fa[k];
         fwd_data[k*XLEN +: XLEN] = fd[k];
      end
   end

   int          checks;
   int          errors;
   bit          m_valid;
   logic [31:0] m_ir, m_npc, m_rs, m_rt, m_hi, m_lo;
   int          m_cnt;
   bit          npc_known;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid   = 1'b0;
      m_ir      = NOP;
      m_npc     = 32'h0;
      m_rs      = 32'h0;
      m_rt      = 32'h0;
      m_hi      = 32'h0;
      m_lo      = 32'h0;
      m_cnt     = 0;
      npc_known = 1'b1;
   endtask

   // Which value does register a read as: youngest valid writer, else the RF.
   function automatic void resolve(input logic [4:0] a, input logic [31:0] rf,
                                   output logic [31:0] v, output bit p);
      int q[$];
      v = rf;
      p = 1'b0;
      if (a == 5'd0) return;
      for (int k = 0; k < NFWD; k++)
         if (fwd_valid[k] && fa[k] == a) q.push_back(k);
      if (q.size() > 0) begin
         v = fd[q[0]];
         p = fwd_pending[q[0]];
      end
   endfunction

   task automatic check_regs();
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("out_ir", out_ir, m_ir);
      chk("out_rs", out_rs, m_rs);
      chk("out_rt", out_rt, m_rt);
      if (npc_known) chk("out_npc", out_npc, m_npc);
      chk("hi_q", hi_q, m_hi);
      chk("lo_q", lo_q, m_lo);
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
   endtask

   // One clock: check combinational outputs, advance the model, check registers.
   task automatic step();
      logic [31:0] vrs, vrt;
      bit          prs, prt, hz, rdy;
      #1;
      resolve(in_ir[25:21], rf_rs, vrs, prs);
      resolve(in_ir[20:16], rf_rt, vrt, prt);
      hz  = in_valid && (prs || prt);
      rdy = !hz && !flush && (!m_valid || out_ready);
      chk("hazard", {31'b0, hazard}, {31'b0, hz});
      chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
      if (!hz) begin
         chk("br_eq", {31'b0, br_eq}, {31'b0, (vrs == vrt)});
         chk("br_gez", {31'b0, br_gez}, {31'b0, ($signed(vrs) >= 0)});
      end
      if (flush) begin
         m_valid = 1'b0; m_ir = NOP; m_rs = 32'h0; m_rt = 32'h0; npc_known = 1'b0;
      end else if (in_valid && rdy) begin
         m_valid = 1'b1; m_ir = in_ir; m_npc = in_npc; m_rs = vrs; m_rt = vrt;
         npc_known = 1'b1;
      end else if (hz && out_ready) begin
         m_valid = 1'b0; m_ir = NOP;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      if (hi_we) m_hi = hi_wdata;
      if (lo_we) m_lo = lo_wdata;
      if (hz && m_cnt < CMAX) m_cnt++;
      @(posedge clk);
      #1;
      check_regs();
   endtask

   initial begin
      logic [31:0] ir;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      in_valid = 1'b0; in_ir = 32'h0; in_npc = 32'h0; rf_rs = 32'h0; rf_rt = 32'h0;
      fwd_valid = '0; fwd_pending = '0; flush = 1'b0; out_ready = 1'b0;
      hi_we = 1'b0; lo_we = 1'b0; hi_wdata = 32'h0; lo_wdata = 32'h0;
      for (int k = 0; k < NFWD; k++) begin fa[k] = '0; fd[k] = '0; end
      model_reset();

      // Reset state
      @(posedge clk);
      #1;
      check_regs();
      rst = 1'b0;

      // Single load, no forwarding
      in_valid = 1'b1; in_ir = 32'h012A4020; in_npc = 32'h0000_0104;
      rf_rs = 32'd5; rf_rt = 32'd7; out_ready = 1'b1;
      step();
      chk("t1_rs", out_rs, 32'd5);
      chk("t1_rt", out_rt, 32'd7);

      // Youngest forwarding source wins; next older when it drops out
      fa[0] = 5'd9; fd[0] = 32'hAA; fa[2] = 5'd9; fd[2] = 32'hBB; fwd_valid = 3'b101;
      step();
      chk("t2_fwd0", out_rs, 32'hAA);
      fwd_valid = 3'b100;
      step();
      chk("t2_fwd2", out_rs, 32'hBB);

      // Register 0 never forwards
      in_ir = 32'h00094020; rf_rs = 32'h0; fa[0] = 5'd0; fd[0] = 32'hFFFF; fwd_valid = 3'b001;
      step();
      chk("t3_r0", out_rs, 32'h0);

      // Load-use stall on Rt, then release
      in_ir = 32'h012A4020; fa[1] = 5'd10; fd[1] = 32'h77;
      fwd_valid = 3'b010; fwd_pending = 3'b010;
      repeat (3) step();
      chk("t4_bubble_v", {31'b0, out_valid}, 32'h0);
      chk("t4_bubble_ir", out_ir, NOP);
      chk("t4_cnt", 32'(stall_cnt), 32'd3);
      fwd_pending = 3'b000;
      step();
      chk("t4_rt", out_rt, 32'h77);

      // Backpressure holds the entry, then flush clears it; HI/LO still written
      out_ready = 1'b0; in_npc = 32'h0000_0200; rf_rt = 32'h1;
      repeat (2) step();
      chk("t5_hold_rt", out_rt, 32'h77);
      flush = 1'b1; hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'h1234; lo_wdata = 32'h5678;
      step();
      chk("t5_flush_v", {31'b0, out_valid}, 32'h0);
      chk("t5_hi", hi_q, 32'h1234);
      chk("t5_lo", lo_q, 32'h5678);
      flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;

      // Asynchronous reset between clock edges
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      chk("t6_hi_async", hi_q, 32'h0);
      chk("t6_lo_async", lo_q, 32'h0);
      chk("t6_valid_async", {31'b0, out_valid}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Stall counter saturation
      out_ready = 1'b1; in_valid = 1'b1; in_ir = 32'h012A4020;
      fa[1] = 5'd10; fwd_valid = 3'b010; fwd_pending = 3'b010;
      repeat (CMAX + 4) step();
      chk("t7_sat", 32'(stall_cnt), 32'(CMAX));
      fwd_pending = 3'b000;

      // Random traffic over a small register set to provoke matches
      repeat (400) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         ir = $urandom;
         ir[25:21] = 5'($urandom_range(0, 3));
         ir[20:16] = 5'($urandom_range(0, 3));
         in_ir  = ir;
         in_npc = $urandom;
         rf_rs  = $urandom;
         rf_rt  = ($urandom_range(0, 3) == 0) ? rf_rs : $urandom;
         for (int k = 0; k < NFWD; k++) begin
            fa[k] = 5'($urandom_range(0, 3));
            fd[k] = $urandom;
         end
         fwd_valid   = 3'($urandom);
         fwd_pending = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
         hi_we    = $urandom_range(0, 1) == 1;
         lo_we    = $urandom_range(0, 1) == 1;
         hi_wdata = $urandom;
         lo_wdata = $urandom;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised decode-to-execute operand stage for the dynamic pipeline.
- Captures IR/NPC from fetch and resolves Rs/Rt operands from an external register file, with N-way priority forwarding.
- Detects load-use hazards, produces branch-compare flags, and holds the HI/LO pair.
- Replaces the fixed cond-code FLOW/STALL/ZERO scheme with a valid/ready handshake plus flush.

Parameters:
- XLEN, 32, datapath width of operands, IR, NPC, HI and LO.
- NFWD, 3, number of forwarding sources; index 0 is the youngest and has highest priority.
- RA_W, 5, register address width.
- CNT_W, 16, width of the saturating stall counter.
- NOP_IR, 0, IR value loaded on reset or flush.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  fetch offers in_ir/in_npc.
- in_ready  out  1  stage accepts this cycle.
- in_ir  in  XLEN  fetched instruction.
- in_npc  in  XLEN  fetched PC+4.
- rf_rs  in  XLEN  register-file read data for in_ir[25:21].
- rf_rt  in  XLEN  register-file read data for in_ir[20:16].
- fwd_valid  in  NFWD  source k carries a register write.
- fwd_pending  in  NFWD  source k value not yet available (load in flight).
- fwd_addr  in  NFWD*RA_W  destination register of source k.
- fwd_data  in  NFWD*XLEN  write data of source k.
- flush  in  1  kill held entry (branch taken / exception).
- out_valid  out  1  held entry valid.
- out_ready  in  1  execute accepts held entry.
- out_ir  out  XLEN  held IR.
- out_npc  out  XLEN  held NPC.
- out_rs  out  XLEN  held resolved Rs.
- out_rt  out  XLEN  held resolved Rt.
- br_eq  out  1  combinational: resolved Rs == resolved Rt for in_ir.
- br_gez  out  1  combinational: resolved Rs[XLEN-1] == 0.
- hazard  out  1  combinational load-use stall request.
- hi_we  in  1  HI write enable.
- lo_we  in  1  LO write enable.
- hi_wdata  in  XLEN  HI write data.
- lo_wdata  in  XLEN  LO write data.
- hi_q  out  XLEN  HI register.
- lo_q  out  XLEN  LO register.
- stall_cnt  out  CNT_W  cycles with in_valid && hazard.

Behaviour:
- Reset (asynchronous, immediate): out_valid=0, out_ir=NOP_IR, out_npc/out_rs/out_rt=0, hi_q=lo_q=0, stall_cnt=0. Reset mid-transfer discards the entry.
- Operand resolution for in_ir:
  - Register 0 never matches a forwarding source and always resolves to rf_rs/rf_rt.
  - Otherwise select the lowest k with fwd_valid[k] && fwd_addr[k]==addr.
  - If no k matches, use the register-file value.
- hazard = in_valid && (the selected source for Rs or Rt has fwd_pending=1). An older non-pending match never overrides a younger pending one.
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Load occurs when in_valid && in_ready: the register captures in_ir, in_npc and the resolved operands; out_valid=1. Latency is 1 cycle.
- Drain occurs when out_valid && out_ready with no load: out_valid=0, and data holds its last value.
- Hold occurs when out_valid && !out_ready: all outputs stable, with no bubble insertion.
- Hazard with out_ready=1 and no flush: a bubble is inserted; out_valid=0 and out_ir=NOP_IR.
- Flush has top priority: out_valid=0, out_ir=NOP_IR, operands=0, no load that cycle.
- br_eq and br_gez use the same forwarded operands as the load path. They are meaningless while hazard=1.
- HI/LO:
  - Independent writes each cycle, unaffected by flush or the handshake.
  - Simultaneous hi_we && lo_we writes both.
- stall_cnt increments when in_valid && hazard and saturates at all-ones.

Decomposition:
- Shared pipeline package:
  - NOP_IR constant.
  - RS/RT field-position constants (25:21, 20:16).
  - Existing COND_* codes, retained for the adapter to legacy stages.
- One natural sub-module: fwd_select (one instance per operand). It takes address, RF value and the forwarding buses, and returns the resolved value plus a pending flag, implemented as a priority loop over NFWD.

Test Plan:
- Reset then a single load: in_ir=0x012A4020, rf_rs=5, rf_rt=7, no fwd, out_ready=1. Next cycle: out_valid=1, out_rs=5, out_rt=7, br_eq=0.
- Priority forward: Rs=$9, fwd0 addr9 data 0xAA, fwd2 addr9 data 0xBB, both valid. Expect out_rs=0xAA. With fwd0 invalid, expect out_rs=0xBB.
- Register-zero guard: in_ir with Rs=$0, fwd0 addr0 data 0xFFFF. Expect out_rs=rf_rs (0).
- Load-use: fwd1 pending, addr matches Rt, held. Expect hazard=1, in_ready=0 and a bubble (out_valid=0, out_ir=0). After 3 cycles, stall_cnt=3. Drop pending: load occurs with fwd1 data.
- Backpressure plus flush: out_ready=0 for 2 cycles, outputs stable and in_ready=0. Assert flush: next cycle out_valid=0, out_ir=NOP_IR, with no load.
- HI/LO: hi_we=lo_we=1 with 0x1234/0x5678 during flush. Next cycle hi_q=0x1234, lo_q=0x5678. Assert async rst mid-cycle: both read 0 immediately.
